// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: word-addressed on-chip data memory answering dbus
// requests with a fixed, parameterised latency and one outstanding request.
// Ports: clk, resetn (async, active-low), dreq (dbus_req_t), dresp (dbus_resp_t).
// Optional macro DBUS_RESP_STALL_EN adds LFSR-driven pseudorandom accept stalls.

package dbus_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

endpackage

module dbus_sram_responder
    import dbus_pkg::*;
#(
    parameter int LATENCY     = 1,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic       clk,
    input  logic       resetn,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] req_idx;
    logic          idle;
    logic          accept_en;
    logic          addr_ok;
    logic          we;
    logic [AW-1:0] widx;
    logic [3:0]    wstrb;
    logic [31:0]   wdat;

    assign req_idx = dreq.addr[AW+1:2];

    // Size, byte offset and aliased high address bits carry no meaning here.
    logic unused_req_bits;
    assign unused_req_bits = ^{dreq.size, dreq.addr[1:0], dreq.addr[31:AW+2]};

`ifdef DBUS_RESP_STALL_EN
    // x^8+x^6+x^5+x^4+1 Fibonacci LFSR gating the accept in IDLE.
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign accept_en = lfsr[0];
`else
    assign accept_en = 1'b1;
`endif

    // Reset gating keeps all handshake outputs low while resetn is held.
    assign addr_ok = resetn && idle && dreq.valid && accept_en;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[widx][8*i +: 8] <= wdat[8*i +: 8];
                end
            end
        end
    end

    generate
        if (LATENCY == 0) begin : g_lat0
            logic [31:0] data_q;

            assign idle  = 1'b1;
            assign we    = addr_ok && (dreq.strobe != 4'd0);
            assign widx  = req_idx;
            assign wstrb = dreq.strobe;
            assign wdat  = dreq.data;

            // Holds the last returned word between handshakes.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    data_q <= 32'd0;
                end else if (addr_ok) begin
                    data_q <= mem[req_idx];
                end
            end

            assign dresp = '{
                addr_ok: addr_ok,
                data_ok: addr_ok,
                data:    addr_ok ? mem[req_idx] : data_q
            };
        end else begin : g_latn
            typedef enum logic [1:0] {
                IDLE,
                WAIT,
                RESP
            } state_t;

            // WAIT spans LATENCY-1 cycles, so the counter is loaded with
            // LATENCY-2 and LATENCY==1 goes straight to RESP.
            localparam int CNT_INIT = (LATENCY >= 2) ? LATENCY - 2 : 0;

            state_t        state;
            logic [3:0]    cnt;
            logic [AW-1:0] idx_q;
            logic [3:0]    strb_q;
            logic [31:0]   wdata_q;
            logic [31:0]   data_q;
            logic          data_ok_q;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    state     <= IDLE;
                    cnt       <= 4'd0;
                    idx_q     <= '0;
                    strb_q    <= 4'd0;
                    wdata_q   <= 32'd0;
                    data_q    <= 32'd0;
                    data_ok_q <= 1'b0;
                end else begin
                    unique case (state)
                        IDLE: begin
                            if (addr_ok) begin
                                idx_q   <= req_idx;
                                strb_q  <= dreq.strobe;
                                wdata_q <= dreq.data;
                                if (LATENCY == 1) begin
                                    state     <= RESP;
                                    data_ok_q <= 1'b1;
                                    data_q    <= mem[req_idx];
                                end else begin
                                    state <= WAIT;
                                    cnt   <= 4'(CNT_INIT);
                                end
                            end
                        end
                        WAIT: begin
                            if (cnt != 4'd0) begin
                                cnt <= cnt - 4'd1;
                            end else begin
                                // Read precedes the write, which lands at
                                // the RESP edge.
                                state     <= RESP;
                                data_ok_q <= 1'b1;
                                data_q    <= mem[idx_q];
                            end
                        end
                        RESP: begin
                            state     <= IDLE;
                            data_ok_q <= 1'b0;
                        end
                        default: begin
                            state     <= IDLE;
                            data_ok_q <= 1'b0;
                        end
                    endcase
                end
            end

            assign idle  = (state == IDLE);
            assign we    = resetn && (state == RESP) && (strb_q != 4'd0);
            assign widx  = idx_q;
            assign wstrb = strb_q;
            assign wdat  = wdata_q;

            assign dresp = '{
                addr_ok: addr_ok,
                data_ok: data_ok_q,
                data:    data_q
            };
        end
    endgenerate

endmodule

// File: tb/tb_dbus_sram_responder.sv
// tb_dbus_sram_responder: self-checking bench for dbus_sram_responder.
// Four instances with LATENCY 0, 2, 3, 4 share one clock.

module tb_dbus_sram_responder;
    import dbus_pkg::*;

    logic       clk = 1'b0;
    logic       rstn [4];
    dbus_req_t  dreq [4];
    dbus_resp_t dresp [4];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            dbus_sram_responder #(
                .LATENCY     ((g == 0) ? 0 : g + 1),
                .DEPTH_WORDS (1024)
            ) u_dut (
                .clk    (clk),
                .resetn (rstn[g]),
                .dreq   (dreq[g]),
                .dresp  (dresp[g])
            );
        end
    endgenerate

    int errs   = 0;
    int checks = 0;

    // Reference memory: word per aliased index plus a known flag.
    logic [31:0] mdl [4][1024];
    bit          kn  [4][1024];

    function automatic int lat_of(int k);
        return (k == 0) ? 0 : k + 1;
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'((a / 4) % 1024);
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One full handshake; requester holds valid until data_ok.
    task automatic req(input int k, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] r);
        int n;
        bit bad;
        int ix;
        logic [31:0] w;
        @(negedge clk);
        dreq[k] = '{valid: 1'b1, addr: a, size: 3'd2, strobe: s, data: d};
        #1;
        n = 0;
        while (!dresp[k].addr_ok && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!dresp[k].addr_ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
            dreq[k].valid = 1'b0;
            r = 32'hx;
            return;
        end
        n = 0;
        bad = 0;
        while (!dresp[k].data_ok && n < 100) begin
            @(negedge clk);
            #1;
            n++;
            if (dresp[k].addr_ok) bad = 1;
        end
        chk("latency", n, lat_of(k));
        chk("no_reaccept", {31'd0, bad}, 32'd0);
        r = dresp[k].data;
        ix = widx(a);
        if (kn[k][ix]) chk("model_rdata", r, mdl[k][ix]);
        w = mdl[k][ix];
        for (int i = 0; i < 4; i++)
            if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        mdl[k][ix] = w;
        if (s == 4'hF) kn[k][ix] = 1;
        @(negedge clk);
        dreq[k].valid = 1'b0;
        #1;
        chk("data_ok_pulse", {31'd0, dresp[k].data_ok}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        bit          ck;
        logic [31:0] exp;
    } vec_t;

    vec_t tv [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int n;
        int bad;
        logic ao4;
        logic [7:0] lf;

        tv[0] = '{32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 0, 32'h0};
        tv[1] = '{32'h0000_0010, 4'h0, 32'h0,         1, 32'hDEAD_BEEF};
        tv[2] = '{32'h0000_1010, 4'h2, 32'h0000_AB00, 1, 32'hDEAD_BEEF};
        tv[3] = '{32'h0000_0010, 4'h0, 32'h0,         1, 32'hDEAD_ABEF};
        tv[4] = '{32'h0000_0014, 4'hF, 32'h0123_4567, 0, 32'h0};
        tv[5] = '{32'h0000_0015, 4'h9, 32'hAA00_00BB, 1, 32'h0123_4567};
        tv[6] = '{32'h0000_4014, 4'h0, 32'h0,         1, 32'hAA23_45BB};
        tv[7] = '{32'hFFFF_F010, 4'h4, 32'h00CC_0000, 1, 32'hDEAD_ABEF};
        tv[8] = '{32'h0000_0012, 4'h0, 32'h0,         1, 32'hDECC_ABEF};

        for (int k = 0; k < 4; k++) begin
            rstn[k] = 1'b0;
            dreq[k] = '0;
            for (int i = 0; i < 1024; i++) kn[k][i] = 0;
        end

        // Reset held with a pending valid request.
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            dreq[k].valid = 1'b1;
            dreq[k].addr  = 32'h10;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_addr_ok", {31'd0, dresp[k].addr_ok}, 32'd0);
            chk("rst_data_ok", {31'd0, dresp[k].data_ok}, 32'd0);
            chk("rst_data", dresp[k].data, 32'd0);
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) rstn[k] = 1'b1;
        #1;
        chk("rel_addr_ok", {31'd0, dresp[1].addr_ok}, 32'd1);
`ifdef DBUS_RESP_STALL_EN
        // Instance 0 never leaves IDLE, so addr_ok mirrors lfsr[0].
        lf = 8'hA5;
        for (int c = 0; c < 16; c++) begin
            chk("lfsr_addr_ok", {31'd0, dresp[0].addr_ok}, {31'd0, lf[0]});
            lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
            if (c == 0) begin
                for (int k = 1; k < 4; k++) dreq[k].valid = 1'b0;
            end
            @(negedge clk);
            #1;
        end
        dreq[0].valid = 1'b0;
`else
        lf = 8'h0;
        #1;
        for (int k = 0; k < 4; k++) dreq[k].valid = 1'b0;
`endif

        // Table-driven sequence on LATENCY=2.
        for (int v = 0; v < 9; v++) begin
            req(1, tv[v].a, tv[v].s, tv[v].d, r);
            if (tv[v].ck) chk($sformatf("vec%0d_rdata", v), r, tv[v].exp);
        end

        // Held valid across one read on LATENCY=3.
        req(2, 32'h40, 4'hF, 32'hCAFE_F00D, r);
        @(negedge clk);
        dreq[2] = '{valid: 1'b1, addr: 32'h40, size: 3'd2,
                    strobe: 4'h0, data: 32'h0};
        #1;
        n = 0;
        while (!dresp[2].addr_ok && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            chk($sformatf("held_addr_ok%0d", c),
                {31'd0, dresp[2].addr_ok}, {31'd0, c == 0});
            chk($sformatf("held_data_ok%0d", c),
                {31'd0, dresp[2].data_ok}, {31'd0, c == 3});
        end
        chk("held_data", dresp[2].data, 32'hCAFE_F00D);
        @(negedge clk);
        #1;
        ao4 = dresp[2].addr_ok;
        chk("held_after_data_ok", {31'd0, dresp[2].data_ok}, 32'd0);
`ifndef DBUS_RESP_STALL_EN
        chk("held_reassert", {31'd0, ao4}, 32'd1);
`endif
        @(negedge clk);
        dreq[2].valid = 1'b0;
        if (ao4) begin
            #1;
            n = 1;
            while (!dresp[2].data_ok && n < 100) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("held_second_lat", n, 32'd3);
            chk("held_second_data", dresp[2].data, 32'hCAFE_F00D);
        end

        // LATENCY=0 back-to-back reads.
        req(0, 32'h0, 4'hF, 32'h1111_1111, r);
        req(0, 32'h4, 4'hF, 32'h2222_2222, r);
        req(0, 32'h8, 4'hF, 32'h3333_3333, r);
`ifndef DBUS_RESP_STALL_EN
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            dreq[0] = '{valid: 1'b1, addr: 32'(j * 4), size: 3'd2,
                        strobe: 4'h0, data: 32'h0};
            #1;
            chk($sformatf("b2b_addr_ok%0d", j),
                {31'd0, dresp[0].addr_ok}, 32'd1);
            chk($sformatf("b2b_data_ok%0d", j),
                {31'd0, dresp[0].data_ok}, 32'd1);
            chk($sformatf("b2b_data%0d", j),
                dresp[0].data, 32'h1111_1111 * (j + 1));
        end
        @(negedge clk);
        dreq[0].valid = 1'b0;
`endif

        // Reset one cycle after accept on LATENCY=4 aborts the write.
        req(3, 32'h20, 4'hF, 32'h0BAD_F00D, r);
        @(negedge clk);
        dreq[3] = '{valid: 1'b1, addr: 32'h20, size: 3'd2,
                    strobe: 4'hF, data: 32'h1234_5678};
        #1;
        n = 0;
        while (!dresp[3].addr_ok && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        rstn[3] = 1'b0;
        dreq[3].valid = 1'b0;
        #1;
        chk("abort_rst_data_ok", {31'd0, dresp[3].data_ok}, 32'd0);
        @(negedge clk);
        rstn[3] = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (dresp[3].data_ok) bad++;
        end
        chk("abort_no_data_ok", bad, 32'd0);
        req(3, 32'h20, 4'h0, 32'h0, r);
        chk("abort_prior_kept", r, 32'h0BAD_F00D);

        // Randomised traffic with aliasing, checked by the model.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 16; i++)
                req(k, 32'(i * 4), 4'hF, $urandom, r);
            for (int t = 0; t < 40; t++) begin
                logic [31:0] a;
                logic [3:0]  s;
                a = ($urandom_range(0, 7) << 12) +
                    ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
                s = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                req(k, a, s, $urandom, r);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
